// File: rtl/aurora_bist_multilane.sv
// Multi-lane PRBS31 BIST: throttled generator on m_axis, self-synchronising checker on s_axis, optional loopback.
// Generator and checker are registered. Loopback is combinational. The generator holds each word until tready, and the checker never backpressures.
module aurora_bist_multilane #(
  parameter int          NUM_LANES     = 4,
  parameter int          DATA_W        = 64,
  parameter int          CNT_W         = 48,
  parameter logic [30:0] SEED          = 31'h1,
  parameter int          LOCK_THRESH   = 16,
  parameter int          UNLOCK_THRESH = 8
) (
  input  logic                           clk,
  input  logic                           areset_n,
  input  logic                           gen_en,
  input  logic                           checker_en,
  input  logic                           loopback_en,
  input  logic [5:0]                     gen_rate,
  output logic [NUM_LANES*DATA_W-1:0]    m_axis_tdata,
  output logic [NUM_LANES-1:0]           m_axis_tvalid,
  input  logic [NUM_LANES-1:0]           m_axis_tready,
  input  logic [NUM_LANES*DATA_W-1:0]    s_axis_tdata,
  input  logic [NUM_LANES-1:0]           s_axis_tvalid,
  output logic [NUM_LANES-1:0]           s_axis_tready,
  output logic [NUM_LANES-1:0]           checker_locked,
  output logic [NUM_LANES*CNT_W-1:0]     checker_samps,
  output logic [NUM_LANES*CNT_W-1:0]     checker_errors
);

  localparam int RUN_W = $clog2(LOCK_THRESH + 1);
  localparam int BAD_W = $clog2(UNLOCK_THRESH + 1);

  // Next DATA_W bits of x^31+x^28+1 from state st; first bit lands in the MSB.
  // With DATA_W >= 31 the successor state is simply the word's low 31 bits.
  function automatic logic [DATA_W-1:0] prbs_word(input logic [30:0] st);
    logic [30:0]       s;
    logic              b;
    logic [DATA_W-1:0] w;
    s = st;
    w = '0;
    for (int k = DATA_W - 1; k >= 0; k--) begin
      b    = s[30] ^ s[27];
      s    = {s[29:0], b};
      w[k] = b;
    end
    return w;
  endfunction

  logic [5:0] phase;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) phase <= 6'd0;
    else           phase <= phase + 6'd1;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [30:0]       lfsr;
    logic [DATA_W-1:0] gen_dat;
    logic              gen_vld;
    logic [DATA_W-1:0] gen_nxt;
    logic [DATA_W-1:0] s_word;
    logic              s_acc;
    logic              good;
    logic              have_prev;
    logic [30:0]       w_prev;
    logic [RUN_W-1:0]  run;
    logic [BAD_W-1:0]  bad_run;
    logic              locked;
    logic [CNT_W-1:0]  samps;
    logic [CNT_W-1:0]  errors;

    assign gen_nxt = prbs_word(lfsr);

    always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
        lfsr    <= SEED + 31'(i);
        gen_dat <= '0;
        gen_vld <= 1'b0;
      end else if (loopback_en) begin
        gen_vld <= 1'b0;
      end else if ((!gen_vld || m_axis_tready[i]) && gen_en && (phase <= gen_rate)) begin
        gen_dat <= gen_nxt;
        lfsr    <= gen_nxt[30:0];
        gen_vld <= 1'b1;
      end else if (m_axis_tready[i]) begin
        gen_vld <= 1'b0;
      end
    end

    assign m_axis_tdata[i*DATA_W +: DATA_W] = loopback_en ? s_axis_tdata[i*DATA_W +: DATA_W] : gen_dat;
    assign m_axis_tvalid[i]                 = loopback_en ? s_axis_tvalid[i] : gen_vld;
    assign s_axis_tready[i]                 = loopback_en ? m_axis_tready[i] : 1'b1;

    assign s_word = s_axis_tdata[i*DATA_W +: DATA_W];
    assign s_acc  = s_axis_tvalid[i] & s_axis_tready[i];
    // All-zero words are rejected so a stuck-at-zero link can never look locked.
    assign good   = (s_word == prbs_word(w_prev)) && (s_word != '0);

    always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
        have_prev <= 1'b0;
        w_prev    <= '0;
        run       <= '0;
        bad_run   <= '0;
        locked    <= 1'b0;
        samps     <= '0;
        errors    <= '0;
      end else if (!checker_en) begin
        have_prev <= 1'b0;
        w_prev    <= '0;
        run       <= '0;
        bad_run   <= '0;
        locked    <= 1'b0;
        samps     <= '0;
        errors    <= '0;
      end else if (s_acc) begin
        w_prev    <= s_word[30:0];
        have_prev <= 1'b1;
        if (have_prev) begin
          if (!locked) begin
            if (!good) begin
              run <= '0;
            end else if (run == RUN_W'(LOCK_THRESH - 1)) begin
              locked  <= 1'b1;
              run     <= '0;
              bad_run <= '0;
            end else begin
              run <= run + RUN_W'(1);
            end
          end else if (good) begin
            bad_run <= '0;
            if (samps != '1) samps <= samps + CNT_W'(1);
          end else begin
            if (errors != '1) errors <= errors + CNT_W'(1);
            if (bad_run == BAD_W'(UNLOCK_THRESH - 1)) begin
              locked  <= 1'b0;
              bad_run <= '0;
              run     <= '0;
            end else begin
              bad_run <= bad_run + BAD_W'(1);
            end
          end
        end
      end
    end

    assign checker_locked[i]                = locked;
    assign checker_samps[i*CNT_W +: CNT_W]  = samps;
    assign checker_errors[i*CNT_W +: CNT_W] = errors;
  end

endmodule

// File: tb/tb_aurora_bist_multilane.sv
// Bench for aurora_bist_multilane: reference PRBS model and monitor, rate and loopback tables, checker corner sequences, randomized checker model.
module tb_aurora_bist_multilane;
  localparam int NL = 4;
  localparam int DW = 64;
  localparam int CW = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              areset_n, gen_en, checker_en, loopback_en, tb_loop, mon_on;
  logic [5:0]        gen_rate;
  logic [NL*DW-1:0]  m_axis_tdata, s_axis_tdata, s_drv_dat, flip_vec;
  logic [NL-1:0]     m_axis_tvalid, m_axis_tready, s_axis_tvalid, s_axis_tready, checker_locked, s_drv_vld;
  logic [NL*CW-1:0]  checker_samps, checker_errors;

  assign s_axis_tdata  = tb_loop ? (m_axis_tdata ^ flip_vec) : s_drv_dat;
  assign s_axis_tvalid = tb_loop ? m_axis_tvalid : s_drv_vld;

  aurora_bist_multilane dut (
    .clk(clk), .areset_n(areset_n), .gen_en(gen_en), .checker_en(checker_en),
    .loopback_en(loopback_en), .gen_rate(gen_rate),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .checker_locked(checker_locked), .checker_samps(checker_samps), .checker_errors(checker_errors)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // PRBS31 as a bit stream: b[n] = b[n-31] ^ b[n-28], seeded oldest-first from the state.
  function automatic logic [63:0] ref_word(input logic [30:0] st);
    logic        bits [0:94];
    logic [63:0] w;
    for (int k = 0; k < 31; k++) bits[k] = st[30-k];
    for (int n = 31; n < 95; n++) bits[n] = bits[n-31] ^ bits[n-28];
    for (int j = 0; j < 64; j++) w[63-j] = bits[31+j];
    return w;
  endfunction

  function automatic logic [CW-1:0] samps_of(input int i);
    return checker_samps[i*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] errs_of(input int i);
    return checker_errors[i*CW +: CW];
  endfunction

  // Generator monitor: every valid word must be the next PRBS word of its lane.
  logic [63:0] mon_w [NL];
  int          mon_cnt [NL];
  int          mon_bad = 0;

  always @(negedge clk) begin
    if (!areset_n) begin
      for (int i = 0; i < NL; i++) begin
        mon_w[i]   = ref_word(31'(i + 1));
        mon_cnt[i] = 0;
      end
    end else if (mon_on) begin
      for (int i = 0; i < NL; i++) begin
        if (m_axis_tvalid[i]) begin
          if (m_axis_tdata[i*DW +: DW] !== mon_w[i]) mon_bad++;
          if (m_axis_tready[i]) begin
            mon_cnt[i]++;
            mon_w[i] = ref_word(mon_w[i][30:0]);
          end
        end
      end
    end
  end

  typedef struct {
    logic [5:0] rate;
    int         exp_words;
  } rate_vec_t;

  typedef struct {
    logic        lb;
    logic [3:0]  svld;
    logic [3:0]  mrdy;
    logic [63:0] dat;
    logic [3:0]  exp_mvld;
    logic [3:0]  exp_srdy;
  } lb_vec_t;

  rate_vec_t   rate_tab [4];
  lb_vec_t     lb_tab [5];
  int          snap [NL];
  logic [63:0] d0, w, base;
  int          stall_bad, rnd_bad;
  logic        vld, ce, good;

  // Checker reference state for the randomized phase.
  logic [63:0] last_w [NL];
  logic        m_hp [NL];
  logic        m_lk [NL];
  logic [30:0] m_prev [NL];
  int          m_run [NL], m_brun [NL];
  longint      m_samps [NL], m_errs [NL];

  initial begin
    rate_tab[0] = '{6'd63, 64};
    rate_tab[1] = '{6'd31, 32};
    rate_tab[2] = '{6'd0,  1};
    rate_tab[3] = '{6'd5,  6};
    lb_tab[0] = '{1'b1, 4'b1010, 4'b0110, 64'hDEAD_BEEF_0123_4567, 4'b1010, 4'b0110};
    lb_tab[1] = '{1'b1, 4'b1111, 4'b0000, 64'h0F0F_F0F0_AAAA_5555, 4'b1111, 4'b0000};
    lb_tab[2] = '{1'b1, 4'b0101, 4'b1111, 64'h8000_0000_0000_0001, 4'b0101, 4'b1111};
    lb_tab[3] = '{1'b0, 4'b1111, 4'b0000, 64'h1234_5678_9ABC_DEF0, 4'b0000, 4'b1111};
    lb_tab[4] = '{1'b0, 4'b1010, 4'b1111, 64'hFFFF_0000_FFFF_0000, 4'b0000, 4'b1111};

    areset_n = 1'b0; gen_en = 1'b0; checker_en = 1'b0; loopback_en = 1'b0; gen_rate = 6'd0;
    m_axis_tready = '0; s_drv_dat = '0; s_drv_vld = '0; flip_vec = '0; tb_loop = 1'b0; mon_on = 1'b1;
    #12;
    chk("reset m_tvalid", 64'(m_axis_tvalid), 64'h0);
    chk("reset locked", 64'(checker_locked), 64'h0);
    chk("reset samps0", 64'(samps_of(0)), 64'h0);
    chk("reset s_tready", 64'(s_axis_tready), 64'hF);
    step(2);

    // Full-rate generation from reset.
    gen_en = 1'b1; gen_rate = 6'd63; m_axis_tready = '1; areset_n = 1'b1;
    step(1);
    chk("first word valid", 64'(m_axis_tvalid), 64'hF);
    chk("lane1 first word seed 2", m_axis_tdata[DW +: DW], ref_word(31'h2));
    chk("lane0 first word seed 1", m_axis_tdata[0 +: DW], ref_word(31'h1));
    for (int i = 0; i < NL; i++) snap[i] = mon_cnt[i];
    step(1000);
    chk("rate63 words lane0", 64'(mon_cnt[0] - snap[0]), 64'd1000);
    chk("rate63 words lane2", 64'(mon_cnt[2] - snap[2]), 64'd1000);

    foreach (rate_tab[r]) begin
      gen_rate = rate_tab[r].rate;
      step(64);
      for (int i = 0; i < NL; i++) snap[i] = mon_cnt[i];
      step(64);
      chk($sformatf("rate %0d words lane0", rate_tab[r].rate), 64'(mon_cnt[0] - snap[0]), 64'(rate_tab[r].exp_words));
      chk($sformatf("rate %0d words lane3", rate_tab[r].rate), 64'(mon_cnt[3] - snap[3]), 64'(rate_tab[r].exp_words));
    end
    gen_rate = 6'd63;
    step(2);

    // Lane 0 stalled for 10 cycles; the others keep streaming.
    m_axis_tready = 4'b1110;
    d0 = m_axis_tdata[0 +: DW];
    for (int i = 0; i < NL; i++) snap[i] = mon_cnt[i];
    stall_bad = 0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (!m_axis_tvalid[0] || m_axis_tdata[0 +: DW] !== d0) stall_bad++;
    end
    chk("stall lane0 held", 64'(stall_bad), 64'd0);
    chk("stall lane0 words", 64'(mon_cnt[0] - snap[0]), 64'd0);
    chk("stall lane1 words", 64'(mon_cnt[1] - snap[1]), 64'd10);
    chk("stall lane3 words", 64'(mon_cnt[3] - snap[3]), 64'd10);
    m_axis_tready = '1;
    step(1);

    // External m->s loop: lock, count, corrupt, unlock.
    tb_loop = 1'b1; checker_en = 1'b1;
    step(16);
    chk("not locked after 16", 64'(checker_locked), 64'h0);
    step(1);
    chk("locked after 17", 64'(checker_locked), 64'hF);
    chk("lock word not counted", 64'(samps_of(0)), 64'd0);
    step(500);
    chk("samps0 after 500", 64'(samps_of(0)), 64'd500);
    chk("samps3 after 500", 64'(samps_of(3)), 64'd500);
    chk("errors0 after 500", 64'(errs_of(0)), 64'd0);
    flip_vec[DW-1] = 1'b1;
    step(1);
    flip_vec = '0;
    step(1);
    chk("flip errors0", 64'(errs_of(0)), 64'd1);
    chk("flip still locked", 64'(checker_locked[0]), 64'd1);
    for (int c = 0; c < 8; c++) begin
      flip_vec[0 +: DW] = {$urandom, $urandom};
      step(1);
    end
    flip_vec = '0;
    chk("8 bad unlock lane0", 64'(checker_locked[0]), 64'd0);
    chk("8 bad errors0", 64'(errs_of(0)), 64'd9);
    chk("samps0 frozen", 64'(samps_of(0)), 64'd501);
    chk("lane1 samps independent", 64'(samps_of(1)), 64'd510);
    chk("lane1 still locked", 64'(checker_locked[1]), 64'd1);

    // Asynchronous reset in the middle of traffic.
    areset_n = 1'b0;
    #1;
    chk("midreset m_tvalid", 64'(m_axis_tvalid), 64'h0);
    chk("midreset locked", 64'(checker_locked), 64'h0);
    chk("midreset samps1", 64'(samps_of(1)), 64'h0);
    chk("midreset errors0", 64'(errs_of(0)), 64'h0);
    step(1);
    areset_n = 1'b1;
    step(1);
    chk("post-reset lane1 word", m_axis_tdata[DW +: DW], ref_word(31'h2));
    step(19);
    chk("relock after reset", 64'(checker_locked), 64'hF);
    checker_en = 1'b0;
    step(1);
    chk("checker_en low locked", 64'(checker_locked), 64'h0);
    chk("checker_en low samps2", 64'(samps_of(2)), 64'h0);
    mon_on = 1'b0;
    chk("generator data vs model", 64'(mon_bad), 64'd0);

    // Combinational loopback table.
    tb_loop = 1'b0; gen_en = 1'b0;
    step(1);
    foreach (lb_tab[t]) begin
      loopback_en = lb_tab[t].lb;
      s_drv_vld = lb_tab[t].svld;
      m_axis_tready = lb_tab[t].mrdy;
      for (int k = 0; k < NL; k++) s_drv_dat[k*DW +: DW] = lb_tab[t].dat ^ 64'(k);
      #1;
      chk($sformatf("lb%0d m_tvalid", t), 64'(m_axis_tvalid), 64'(lb_tab[t].exp_mvld));
      chk($sformatf("lb%0d s_tready", t), 64'(s_axis_tready), 64'(lb_tab[t].exp_srdy));
      if (lb_tab[t].lb) begin
        chk($sformatf("lb%0d lane0 data", t), m_axis_tdata[0 +: DW], lb_tab[t].dat);
        chk($sformatf("lb%0d lane3 data", t), m_axis_tdata[3*DW +: DW], lb_tab[t].dat ^ 64'd3);
      end
      step(1);
    end

    // All-zero input through loopback must never lock.
    loopback_en = 1'b1; m_axis_tready = '1; s_drv_vld = '1; s_drv_dat = '0; checker_en = 1'b1;
    step(30);
    chk("zero input locked", 64'(checker_locked), 64'h0);
    chk("zero input samps0", 64'(samps_of(0)), 64'h0);
    chk("zero input errors0", 64'(errs_of(0)), 64'h0);

    // Randomized checker stream against the reference model.
    loopback_en = 1'b0; checker_en = 1'b0; s_drv_vld = '0;
    step(1);
    for (int i = 0; i < NL; i++) begin
      last_w[i] = ref_word(31'($urandom_range(1, 1000000)));
      m_hp[i] = 1'b0; m_lk[i] = 1'b0; m_prev[i] = '0;
      m_run[i] = 0; m_brun[i] = 0; m_samps[i] = 0; m_errs[i] = 0;
    end
    rnd_bad = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ce = !(cyc >= 300 && cyc <= 302);
      for (int i = 0; i < NL; i++) begin
        vld = ($urandom_range(0, 9) < 7);
        base = (last_w[i][30:0] == 31'd0) ? ref_word(31'($urandom_range(1, 1000000))) : ref_word(last_w[i][30:0]);
        case ($urandom_range(0, 99)) inside
          [0:94]:  w = base;
          [95:97]: w = {$urandom, $urandom};
          default: w = 64'd0;
        endcase
        s_drv_dat[i*DW +: DW] = w;
        s_drv_vld[i] = vld;
        if (vld) last_w[i] = w;
        if (!ce) begin
          m_hp[i] = 1'b0; m_lk[i] = 1'b0; m_run[i] = 0; m_brun[i] = 0; m_samps[i] = 0; m_errs[i] = 0;
        end else if (vld) begin
          if (m_hp[i]) begin
            good = (w == ref_word(m_prev[i])) && (w != 64'd0);
            if (!m_lk[i]) begin
              m_run[i] = good ? m_run[i] + 1 : 0;
              if (m_run[i] == 16) begin m_lk[i] = 1'b1; m_run[i] = 0; m_brun[i] = 0; end
            end else if (good) begin
              m_samps[i]++; m_brun[i] = 0;
            end else begin
              m_errs[i]++; m_brun[i]++;
              if (m_brun[i] == 8) begin m_lk[i] = 1'b0; m_brun[i] = 0; m_run[i] = 0; end
            end
          end
          m_hp[i] = 1'b1;
          m_prev[i] = w[30:0];
        end
      end
      checker_en = ce;
      step(1);
      for (int i = 0; i < NL; i++)
        if (checker_locked[i] !== m_lk[i] || samps_of(i) !== CW'(m_samps[i]) || errs_of(i) !== CW'(m_errs[i]))
          rnd_bad++;
    end
    chk("random stream mismatch cycles", 64'(rnd_bad), 64'd0);
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("random samps lane%0d", i), 64'(samps_of(i)), 64'(m_samps[i]));
      chk($sformatf("random errors lane%0d", i), 64'(errs_of(i)), 64'(m_errs[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
